// File: rtl/uart_frame_loader_if.sv
// Signal bundle between the UART receiver, the frame loader and the systolic stage.
// The slave modport is the loader's view; master is the upstream/downstream environment.
interface uart_frame_loader_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              sys_enable;
  logic [DATA_W-1:0] in_data;
  logic              sin_en;
  logic              busy;
  logic              overrun;
  logic              timeout;

  modport master (
    output rx_data, rx_valid, sys_enable,
    input  in_data, sin_en, busy, overrun, timeout
  );

  modport slave (
    input  rx_data, rx_valid, sys_enable,
    output in_data, sin_en, busy, overrun, timeout
  );
endinterface

// File: rtl/uart_frame_loader.sv
// Buffers one frame of UART bytes, replays it to the systolic stage as a gap-free
// burst, then waits (with timeout) for the consumer's done strobe.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | empty buffer, first rx byte lands at index 0
// S_FILL   | collecting bytes until index FRAME_LEN-1 is written
// S_STREAM | replaying mem[0..FRAME_LEN-1], one byte per clock
// S_WAIT   | burst done, waiting for sys_enable or the timeout
module uart_frame_loader #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 9,
  parameter int ADDR_W    = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  uart_frame_loader_if.slave bus_if
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_STREAM = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  localparam int                RD_W      = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [RD_W-1:0]   RD_END    = RD_W'(FRAME_LEN);
  localparam logic [7:0]        WAIT_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  // One extra bit so the read pointer can sit one past the last byte for the
  // trailing STREAM cycle, even when FRAME_LEN == 2**ADDR_W.
  logic [RD_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;

  logic [DATA_W-1:0]   in_data_q, in_data_d;
  logic                sin_en_q, sin_en_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;

  logic [DATA_W-1:0]   mem_q [2**ADDR_W];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wait_cnt_q <= '0;
      in_data_q  <= '0;
      sin_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      in_data_q  <= in_data_d;
      sin_en_q   <= sin_en_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
      timeout_q  <= timeout_d;
    end
  end

  // Frame storage needs no reset: every slot is rewritten before it is replayed.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= bus_if.rx_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wait_cnt_d = wait_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (bus_if.rx_valid) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          wr_ptr_d  = ADDR_W'(1);
          state_d   = S_FILL;
        end
      end
      S_FILL: begin
        if (bus_if.rx_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (wr_ptr_q == LAST_IDX) begin
            rd_ptr_d = '0;
            state_d  = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (rd_ptr_q == RD_END) begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end else begin
          rd_ptr_d = rd_ptr_q + RD_W'(1);
        end
      end
      S_WAIT: begin
        if (bus_if.sys_enable || (wait_cnt_q == WAIT_LAST)) begin
          wr_ptr_d = '0;
          state_d  = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    sin_en_d  = 1'b0;
    in_data_d = '0;
    if ((state_q == S_STREAM) && (rd_ptr_q != RD_END)) begin
      sin_en_d  = 1'b1;
      in_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
    end
    busy_d    = (state_d != S_IDLE);
    overrun_d = bus_if.rx_valid && ((state_q == S_STREAM) || (state_q == S_WAIT));
    // A simultaneous sys_enable completes normally and suppresses the pulse.
    timeout_d = (state_q == S_WAIT) && !bus_if.sys_enable && (wait_cnt_q == WAIT_LAST);
  end

  assign bus_if.in_data = in_data_q;
  assign bus_if.sin_en  = sin_en_q;
  assign bus_if.busy    = busy_q;
  assign bus_if.overrun = overrun_q;
  assign bus_if.timeout = timeout_q;

endmodule
